// File: rtl/alu_nonpipe.sv
// alu_nonpipe: single-cycle ALU with registered result and flags.
// The result is computed combinationally from A/B/OP and captured on the
// next rising edge, so latency is exactly one clock and there is no stall.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   A, B       in   WIDTH-bit operands (unsigned; signed view used for V)
//   OP         in   2'b00 ADD, 2'b01 SUB, 2'b10 AND, 2'b11 OR
//   IN_VALID   in   operands/opcode valid this cycle
//   Y          out  registered result
//   OUT_VALID  out  Y and flags carry a new result this cycle
//   C          out  carry (ADD) / borrow (SUB), 0 for logic ops
//   Z          out  Y == 0
//   N          out  Y[WIDTH-1]
//   V          out  two's-complement overflow, 0 for logic ops
module alu_nonpipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       OP,
  input  logic             IN_VALID,
  output logic [WIDTH-1:0] Y,
  output logic             OUT_VALID,
  output logic             C,
  output logic             Z,
  output logic             N,
  output logic             V
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_a_msb;
  logic             w_b_msb;
  logic             w_r_msb;

  logic [WIDTH-1:0] r_y;
  logic             r_out_valid;
  logic             r_c;
  logic             r_z;
  logic             r_n;
  logic             r_v;

  assign w_sum   = {1'b0, A} + {1'b0, B};
  // Extended subtraction wraps negative when A < B, so the top bit is the borrow.
  assign w_diff  = {1'b0, A} - {1'b0, B};
  assign w_a_msb = A[WIDTH-1];
  assign w_b_msb = B[WIDTH-1];
  assign w_r_msb = w_res[WIDTH-1];

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    unique case (OP)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_a_msb == w_b_msb) && (w_res[WIDTH-1] != w_a_msb);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (w_a_msb != w_b_msb) && (w_res[WIDTH-1] != w_a_msb);
      end
      OP_AND: w_res = A & B;
      OP_OR:  w_res = A | B;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y         <= '0;
      r_c         <= 1'b0;
      r_z         <= 1'b1;
      r_n         <= 1'b0;
      r_v         <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= IN_VALID;
      if (IN_VALID) begin
        r_y <= w_res;
        r_c <= w_c;
        r_z <= (w_res == '0);
        r_n <= w_r_msb;
        r_v <= w_v;
      end
    end
  end

  assign Y         = r_y;
  assign OUT_VALID = r_out_valid;
  assign C         = r_c;
  assign Z         = r_z;
  assign N         = r_n;
  assign V         = r_v;

endmodule

// File: tb/tb_alu_nonpipe.sv
module tb_alu_nonpipe;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       OP;
  logic             IN_VALID;
  logic [WIDTH-1:0] Y;
  logic             OUT_VALID;
  logic             C;
  logic             Z;
  logic             N;
  logic             V;

  int checks = 0;
  int errors = 0;

  alu_nonpipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .IN_VALID  (IN_VALID),
    .Y         (Y),
    .OUT_VALID (OUT_VALID),
    .C         (C),
    .Z         (Z),
    .N         (N),
    .V         (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic r, input logic vld, input logic [1:0] op,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    rst      = r;
    IN_VALID = vld;
    OP       = op;
    A        = a;
    B        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] y,
                       input logic c, input logic z, input logic n,
                       input logic v, input logic ov);
    logic [WIDTH+4:0] obs;
    logic [WIDTH+4:0] exp;
    obs = {Y, C, Z, N, V, OUT_VALID};
    exp = {y, c, z, n, v, ov};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed Y=%0d C=%b Z=%b N=%b V=%b OV=%b, expected Y=%0d C=%b Z=%b N=%b V=%b OV=%b",
             tag, Y, C, Z, N, V, OUT_VALID, y, c, z, n, v, ov);
    end
  endtask

  initial begin
    rst = 1'b1; IN_VALID = 1'b0; OP = 2'b00; A = '0; B = '0;

    // Reset with a valid ADD present: operation discarded.
    step(1, 1, 2'b00, 8'd10, 8'd5);
    check("reset",        8'd0,   0, 1, 0, 0, 0);

    step(0, 1, 2'b00, 8'd10, 8'd5);
    check("add_10_5",     8'd15,  0, 0, 0, 0, 1);
    step(0, 1, 2'b01, 8'd20, 8'd7);
    check("sub_20_7",     8'd13,  0, 0, 0, 0, 1);
    step(0, 1, 2'b01, 8'd5, 8'd7);
    check("sub_5_7",      8'd254, 1, 0, 1, 0, 1);
    step(0, 1, 2'b10, 8'hAA, 8'hCC);
    check("and_aa_cc",    8'h88,  0, 0, 1, 0, 1);
    step(0, 1, 2'b11, 8'hAA, 8'hCC);
    check("or_aa_cc",     8'hEE,  0, 0, 1, 0, 1);
    step(0, 1, 2'b00, 8'd200, 8'd100);
    check("add_200_100",  8'd44,  1, 0, 0, 0, 1);
    step(0, 1, 2'b00, 8'd100, 8'd100);
    check("add_100_100",  8'd200, 0, 0, 1, 1, 1);
    step(0, 1, 2'b01, 8'd7, 8'd7);
    check("sub_7_7",      8'd0,   0, 1, 0, 0, 1);
    step(0, 1, 2'b01, 8'h80, 8'h01);
    check("sub_80_1",     8'h7F,  0, 0, 0, 1, 1);
    step(0, 1, 2'b00, 8'h80, 8'h80);
    check("add_80_80",    8'h00,  1, 1, 0, 1, 1);

    // Hold for three idle cycles while inputs wiggle.
    step(0, 0, 2'b10, 8'hFF, 8'h0F);
    check("hold_1",       8'h00,  1, 1, 0, 1, 0);
    step(0, 0, 2'b11, 8'h12, 8'h34);
    check("hold_2",       8'h00,  1, 1, 0, 1, 0);
    step(0, 0, 2'b01, 8'h01, 8'h02);
    check("hold_3",       8'h00,  1, 1, 0, 1, 0);

    // Logic op clears carry/overflow left by the previous arithmetic.
    step(0, 1, 2'b10, 8'hFF, 8'h0F);
    check("and_ff_0f",    8'h0F,  0, 0, 0, 0, 1);
    step(0, 1, 2'b11, 8'h00, 8'h00);
    check("or_zero",      8'h00,  0, 1, 0, 0, 1);
    step(0, 1, 2'b00, 8'hFF, 8'h01);
    check("add_ff_1",     8'h00,  1, 1, 0, 0, 1);

    // Reset in the middle of traffic, then recovery.
    step(0, 1, 2'b00, 8'd60, 8'd3);
    check("add_60_3",     8'd63,  0, 0, 0, 0, 1);
    step(1, 1, 2'b00, 8'd1, 8'd1);
    check("reset_w_add",  8'd0,   0, 1, 0, 0, 0);
    step(0, 0, 2'b00, 8'd9, 8'd9);
    check("post_rst_idle", 8'd0,  0, 1, 0, 0, 0);
    step(0, 1, 2'b00, 8'd1, 8'd1);
    check("first_after_rst", 8'd2, 0, 0, 0, 0, 1);
    step(0, 1, 2'b01, 8'd0, 8'd1);
    check("sub_0_1",      8'hFF,  1, 0, 1, 0, 1);
    step(0, 0, 2'b00, 8'd0, 8'd0);
    check("idle_end",     8'hFF,  1, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
